// File: rtl/noc_router_4port.sv
// Single-source wormhole router: steers flit payloads into four per-destination
// FIFOs and drains them round-robin into four registered destination buffers.
module noc_router_4port #(
  parameter int DataWidth = 13,
  parameter int FifoDepth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [DataWidth-1:0] src_data,
  output logic [7:0]           buffer00,
  output logic [7:0]           buffer01,
  output logic [7:0]           buffer10,
  output logic [7:0]           buffer11,
  output logic                 dst_valid,
  output logic [1:0]           dst_port,
  input  logic                 dst_ready
);

  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = PtrW + 1;

  if (DataWidth != 13) begin : g_bad_width
    $error("noc_router_4port: DataWidth must be 13");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("noc_router_4port: FifoDepth must be a power of 2 and >= 2");
  end

  typedef enum logic {HEAD, BODY} state_e;

  state_e              state_q, state_d;
  logic [1:0]          locked_port_q, locked_port_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [7:0]          mem_q [4][FifoDepth];
  logic [7:0]          mem_d [4][FifoDepth];
  logic [PtrW-1:0]     wr_ptr_q [4];
  logic [PtrW-1:0]     wr_ptr_d [4];
  logic [PtrW-1:0]     rd_ptr_q [4];
  logic [PtrW-1:0]     rd_ptr_d [4];
  logic [CntW-1:0]     count_q [4];
  logic [CntW-1:0]     count_d [4];
  logic [7:0]          buf_q [4];
  logic [7:0]          buf_d [4];
  logic                dst_valid_q, dst_valid_d;
  logic [1:0]          dst_port_q, dst_port_d;

  logic [1:0]          target;
  logic                accept;
  logic                push;
  logic                found;
  logic                pop;
  logic [1:0]          winner;
  logic [1:0]          scan;

  // Flow control looks only at registered counts, so a pop this cycle never frees space.
  always_comb begin
    target    = (state_q == HEAD) ? src_data[12:11] : locked_port_q;
    src_ready = rst && (count_q[target] != CntW'(FifoDepth));
    accept    = src_valid && src_ready;
    push      = accept && (src_data[10:9] == 2'b01 || src_data[10:9] == 2'b10);
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      scan = rr_ptr_q + 2'(i);
      if (!found && count_q[scan] != '0) begin
        found  = 1'b1;
        winner = scan;
      end
    end
    pop = dst_ready && found;
  end

  always_comb begin
    state_d       = state_q;
    locked_port_d = locked_port_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    buf_d         = buf_q;
    rr_ptr_d      = rr_ptr_q;
    dst_valid_d   = pop;
    dst_port_d    = dst_port_q;

    if (push) begin
      mem_d[target][wr_ptr_q[target]] = src_data[8:1];
      wr_ptr_d[target] = wr_ptr_q[target] + PtrW'(1);
    end
    if (pop) begin
      buf_d[winner]    = mem_q[winner][rd_ptr_q[winner]];
      rd_ptr_d[winner] = rd_ptr_q[winner] + PtrW'(1);
      dst_port_d       = winner;
      rr_ptr_d         = winner + 2'd1;
    end
    for (int unsigned p = 0; p < 4; p++) begin
      case ({push && target == 2'(p), pop && winner == 2'(p)})
        2'b10:   count_d[p] = count_q[p] + CntW'(1);
        2'b01:   count_d[p] = count_q[p] - CntW'(1);
        default: count_d[p] = count_q[p];
      endcase
    end

    if (accept) begin
      if (src_data[0]) begin
        state_d = HEAD;
      end else if (state_q == HEAD) begin
        state_d       = BODY;
        locked_port_d = target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= HEAD;
      locked_port_q <= '0;
      rr_ptr_q      <= '0;
      dst_valid_q   <= 1'b0;
      dst_port_q    <= '0;
      for (int unsigned p = 0; p < 4; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        count_q[p]  <= '0;
        buf_q[p]    <= '0;
      end
    end else begin
      state_q       <= state_d;
      locked_port_q <= locked_port_d;
      rr_ptr_q      <= rr_ptr_d;
      dst_valid_q   <= dst_valid_d;
      dst_port_q    <= dst_port_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      buf_q         <= buf_d;
    end
  end

  // Storage needs no reset: emptiness is tracked entirely by the counts.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign buffer00  = buf_q[0];
  assign buffer01  = buf_q[1];
  assign buffer10  = buf_q[2];
  assign buffer11  = buf_q[3];
  assign dst_valid = dst_valid_q;
  assign dst_port  = dst_port_q;

endmodule

// File: tb/tb_noc_router_4port.sv
// Bench for noc_router_4port: per-cycle vector table plus scoreboarded
// sequences for backpressure, null flits, mid-packet reset and round-robin.
module tb_noc_router_4port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic [12:0] src_data = '0;
  logic [7:0]  buffer00, buffer01, buffer10, buffer11;
  logic        dst_valid;
  logic [1:0]  dst_port;
  logic        dst_ready = 1'b0;

  noc_router_4port #(.DataWidth(13), .FifoDepth(4)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .buffer00(buffer00), .buffer01(buffer01), .buffer10(buffer10), .buffer11(buffer11),
    .dst_valid(dst_valid), .dst_port(dst_port), .dst_ready(dst_ready)
  );

  always #5 clk = ~clk;

  logic [7:0] bufs [4];
  assign bufs[0] = buffer00;
  assign bufs[1] = buffer01;
  assign bufs[2] = buffer10;
  assign bufs[3] = buffer11;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_q [4][$];
  int          got_ports [$];
  logic        model_body = 1'b0;
  logic [1:0]  model_lock = '0;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [12:0] data;
    logic        rdy;
    logic        srdy;
    logic        dv;
    logic [1:0]  port;
    logic [7:0]  b [4];
  } vec_t;

  vec_t tbl [8];

  function automatic logic [12:0] mkf(input logic [1:0] a, input logic [1:0] pt,
                                      input logic [7:0] p, input logic e);
    return {a, pt, p, e};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_accept(input logic [12:0] d);
    logic [1:0] t;
    t = model_body ? model_lock : d[12:11];
    if (d[10:9] == 2'b01 || d[10:9] == 2'b10) exp_q[t].push_back(d[8:1]);
    if (d[0]) model_body = 1'b0;
    else begin
      if (!model_body) model_lock = t;
      model_body = 1'b1;
    end
  endtask

  task automatic model_reset();
    model_body = 1'b0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < 4; i++) n += exp_q[i].size();
    return n;
  endfunction

  // Scoreboard: every delivery must match the oldest expected payload of its port.
  always @(posedge clk) begin
    int p;
    #2;
    if (rst && dst_valid === 1'b1) begin
      p = int'(dst_port);
      got_ports.push_back(p);
      if (exp_q[p].size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_delivery: port %0d got %0h, expected no delivery", p, bufs[p]);
      end else begin
        check($sformatf("deliver_p%0d", p), bufs[p], exp_q[p].pop_front());
      end
    end
  end

  task automatic send(input logic [12:0] d, input logic acc);
    @(negedge clk);
    src_valid = 1'b1;
    src_data  = d;
    #1 check($sformatf("src_ready_%0h", d), src_ready, acc);
    @(posedge clk);
    if (acc) model_accept(d);
    #1 src_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    src_valid = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_drain(input int unsigned max_cycles);
    int unsigned c = 0;
    while (pending() != 0 && c < max_cycles) begin
      @(posedge clk);
      c++;
    end
    #3;
    check("drain_pending", pending(), 0);
  endtask

  task automatic check_order(input string name, input int exp_ord [], input int n);
    check({name, "_count"}, got_ports.size(), n);
    for (int k = 0; k < n; k++)
      if (k < got_ports.size()) check($sformatf("%s_%0d", name, k), got_ports[k], exp_ord[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int ord3 [] = '{0, 3, 0, 3, 3, 3};
    int ord6 [] = '{0, 1, 2, 3, 0, 1, 2, 3};

    //           rst   vld   data                       rdy   srdy  dv    port  buffers
    tbl[0] = '{1'b0, 1'b0, 13'h0,                    1'b1, 1'b0, 1'b0, 2'd0, '{8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[1] = '{1'b1, 1'b1, mkf(2'd0,2'd1,8'hAB,1'b1), 1'b1, 1'b1, 1'b0, 2'd0, '{8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[2] = '{1'b1, 1'b0, 13'h0,                    1'b1, 1'b1, 1'b1, 2'd0, '{8'hAB, 8'h00, 8'h00, 8'h00}};
    tbl[3] = '{1'b1, 1'b1, mkf(2'd1,2'd2,8'hCD,1'b0), 1'b1, 1'b1, 1'b0, 2'd0, '{8'hAB, 8'h00, 8'h00, 8'h00}};
    tbl[4] = '{1'b1, 1'b1, mkf(2'd2,2'd1,8'hEF,1'b1), 1'b1, 1'b1, 1'b1, 2'd1, '{8'hAB, 8'hCD, 8'h00, 8'h00}};
    tbl[5] = '{1'b1, 1'b1, mkf(2'd2,2'd1,8'h12,1'b1), 1'b1, 1'b1, 1'b1, 2'd1, '{8'hAB, 8'hEF, 8'h00, 8'h00}};
    tbl[6] = '{1'b1, 1'b0, 13'h0,                    1'b1, 1'b1, 1'b1, 2'd2, '{8'hAB, 8'hEF, 8'h12, 8'h00}};
    tbl[7] = '{1'b1, 1'b0, 13'h0,                    1'b1, 1'b1, 1'b0, 2'd2, '{8'hAB, 8'hEF, 8'h12, 8'h00}};

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst       = tbl[i].rst;
      src_valid = tbl[i].vld;
      src_data  = tbl[i].data;
      dst_ready = tbl[i].rdy;
      #1 check($sformatf("v%0d_src_ready", i), src_ready, tbl[i].srdy);
      @(posedge clk);
      if (!tbl[i].rst) model_reset();
      else if (tbl[i].vld && tbl[i].srdy) model_accept(tbl[i].data);
      #1;
      check($sformatf("v%0d_dst_valid", i), dst_valid, tbl[i].dv);
      if (tbl[i].dv) check($sformatf("v%0d_dst_port", i), dst_port, tbl[i].port);
      for (int b = 0; b < 4; b++) check($sformatf("v%0d_buf%0d", i, b), bufs[b], tbl[i].b[b]);
    end
    @(negedge clk);
    src_valid = 1'b0;

    // Backpressure on port 11, port 00 still flowing, then interleaved drain.
    do_reset();
    dst_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(mkf(2'd3, 2'd1, 8'h30 + 8'(i), 1'b1), 1'b1);
    send(mkf(2'd3, 2'd1, 8'h34, 1'b1), 1'b0);
    send(mkf(2'd0, 2'd1, 8'h40, 1'b1), 1'b1);
    send(mkf(2'd0, 2'd2, 8'h41, 1'b1), 1'b1);
    got_ports.delete();
    @(negedge clk);
    dst_ready = 1'b1;
    wait_drain(30);
    repeat (2) @(negedge clk);
    check_order("drain_order", ord3, 6);

    // Null/reserved flits consume but deliver nothing; reserved head still locks.
    send(mkf(2'd2, 2'd1, 8'h5A, 1'b1), 1'b1);
    wait_drain(10);
    send(mkf(2'd2, 2'd0, 8'h11, 1'b1), 1'b1);
    send(mkf(2'd2, 2'd3, 8'h22, 1'b0), 1'b1);
    repeat (3) @(negedge clk);
    check("null_buf10_hold", buffer10, 8'h5A);
    send(mkf(2'd1, 2'd1, 8'h55, 1'b1), 1'b1);
    wait_drain(10);
    check("locked_buf10", buffer10, 8'h55);
    check("locked_buf01_hold", buffer01, 8'h00);
    send(mkf(2'd1, 2'd1, 8'h66, 1'b1), 1'b1);
    wait_drain(10);
    check("head_again_buf01", buffer01, 8'h66);

    // Reset in the middle of a packet with data still queued.
    dst_ready = 1'b0;
    send(mkf(2'd1, 2'd1, 8'h60, 1'b0), 1'b1);
    send(mkf(2'd3, 2'd2, 8'h61, 1'b0), 1'b1);
    @(negedge clk);
    rst       = 1'b0;
    src_valid = 1'b1;
    src_data  = mkf(2'd1, 2'd1, 8'h62, 1'b1);
    #1 check("src_ready_in_reset", src_ready, 1'b0);
    @(posedge clk);
    model_reset();
    #1;
    for (int b = 0; b < 4; b++) check($sformatf("rst_buf%0d", b), bufs[b], 8'h00);
    check("rst_dst_valid", dst_valid, 1'b0);
    check("rst_dst_port", dst_port, 2'd0);
    @(negedge clk);
    rst       = 1'b1;
    src_valid = 1'b0;
    dst_ready = 1'b1;
    send(mkf(2'd2, 2'd1, 8'h70, 1'b1), 1'b1);
    wait_drain(10);
    repeat (4) @(negedge clk);
    check("post_rst_buf10", buffer10, 8'h70);
    check("post_rst_buf01", buffer01, 8'h00);

    // Pre-filled FIFOs drain strictly round-robin, one delivery per cycle.
    do_reset();
    dst_ready = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int p = 3; p >= 0; p--) send(mkf(2'(p), 2'd2, 8'h80 + 8'(r * 4 + p), 1'b1), 1'b1);
    got_ports.delete();
    @(negedge clk);
    dst_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 check($sformatf("rr_dv_%0d", k), dst_valid, 1'b1);
    end
    @(posedge clk);
    #1 check("rr_dv_idle", dst_valid, 1'b0);
    #2;
    check_order("rr_order", ord6, 8);
    wait_drain(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
